// File: rtl/led_pwm_fader.sv
// LED PWM fader: turns the blinker's square wave into soft fade edges on the LED pin.
// Latency: pwm_out is registered, one cycle behind pwm_cnt/duty; busy/level_on decode the state register.
// Backpressure: none; the PWM counter is free-running and duty only moves at PWM period boundaries.
module led_pwm_fader #(
  parameter int PWM_BITS  = 8,
  parameter int DUTY_STEP = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                blink_in,
  input  logic                enable,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] duty,
  output logic                busy,
  output logic                level_on
);

  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;
  localparam logic [1:0] S_ON   = 2'd3;

  localparam logic [PWM_BITS-1:0] MAX   = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS:0]   MAX_X = {1'b0, MAX};
  localparam logic [PWM_BITS:0]   STEP  = (PWM_BITS+1)'(DUTY_STEP);

  logic [1:0]          r_state;
  logic [PWM_BITS-1:0] r_duty;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                r_pwm_out;

  logic                w_target;
  logic                w_period_end;
  logic [PWM_BITS:0]   w_sum;
  logic [PWM_BITS:0]   w_diff;
  logic                w_sum_sat;
  logic                w_diff_zero;
  logic [1:0]          w_state_nxt;
  logic [PWM_BITS-1:0] w_duty_nxt;
  logic                w_pwm_nxt;

  // Upstream blinker shares this clock, so the target level is used without synchronisers.
  assign w_target     = blink_in & enable;
  assign w_period_end = (r_pwm_cnt == MAX);

  // One extra bit lets the step detect overflow past MAX and underflow below zero.
  assign w_sum       = {1'b0, r_duty} + STEP;
  assign w_diff      = {1'b0, r_duty} - STEP;
  assign w_sum_sat   = (w_sum >= MAX_X);
  assign w_diff_zero = w_diff[PWM_BITS] || (w_diff == '0);

  // Next state and duty; a direction change takes priority over a step at period end.
  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    case (r_state)
      S_OFF: begin
        w_duty_nxt = '0;
        if (w_target) begin
          w_state_nxt = S_UP;
        end
      end
      S_UP: begin
        if (!w_target) begin
          w_state_nxt = S_DOWN;
        end else if (w_period_end) begin
          if (w_sum_sat) begin
            w_duty_nxt  = MAX;
            w_state_nxt = S_ON;
          end else begin
            w_duty_nxt = w_sum[PWM_BITS-1:0];
          end
        end
      end
      S_ON: begin
        w_duty_nxt = MAX;
        if (!w_target) begin
          w_state_nxt = S_DOWN;
        end
      end
      S_DOWN: begin
        if (w_target) begin
          w_state_nxt = S_UP;
        end else if (w_period_end) begin
          if (w_diff_zero) begin
            w_duty_nxt  = '0;
            w_state_nxt = S_OFF;
          end else begin
            w_duty_nxt = w_diff[PWM_BITS-1:0];
          end
        end
      end
      default: begin
        w_state_nxt = S_OFF;
        w_duty_nxt  = '0;
      end
    endcase
  end

  // PWM level from this cycle's counter and duty; OFF and ON bypass the compare.
  always_comb begin
    w_pwm_nxt = 1'b0;
    case (r_state)
      S_ON:         w_pwm_nxt = 1'b1;
      S_UP, S_DOWN: w_pwm_nxt = (r_pwm_cnt < r_duty);
      default:      w_pwm_nxt = 1'b0;
    endcase
  end

  // State, duty, free-running counter and the registered LED drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_OFF;
      r_duty    <= '0;
      r_pwm_cnt <= '0;
      r_pwm_out <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_duty    <= w_duty_nxt;
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      r_pwm_out <= w_pwm_nxt;
    end
  end

  assign pwm_out  = r_pwm_out;
  assign duty     = r_duty;
  assign busy     = (r_state == S_UP) || (r_state == S_DOWN);
  assign level_on = (r_state == S_ON);

endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader with PWM_BITS=4, DUTY_STEP=4 (period 16, MAX 15).
// Expected duty steps, per-period high counts and PWM bits are queued as stimulus is applied.
// Outputs are sampled 1 time unit after each rising edge.
module tb_led_pwm_fader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       blink_in = 1'b1;
  logic       enable = 1'b1;
  logic       pwm_out;
  logic [3:0] duty;
  logic       busy;
  logic       level_on;

  int checks = 0;
  int errors = 0;

  logic [3:0] tb_cnt = 4'd0;
  logic [3:0] exp_q[$];
  int         hi_q[$];
  logic       exp_bit_q[$];

  led_pwm_fader #(.PWM_BITS(4), .DUTY_STEP(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .blink_in (blink_in),
    .enable   (enable),
    .pwm_out  (pwm_out),
    .duty     (duty),
    .busy     (busy),
    .level_on (level_on)
  );

  always #5 clk = ~clk;

  // Reference position inside the PWM period.
  always @(posedge clk) begin
    if (rst) tb_cnt <= 4'd0;
    else     tb_cnt <= tb_cnt + 4'd1;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_duty(input logic [3:0] v, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (duty === v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; blink_in = 1'b1; enable = 1'b1;
    repeat (3) step();
    checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm_out: got %b expected 0", pwm_out); end
    checks++; if (duty !== 4'd0) begin errors++; $display("FAIL reset_duty: got %0d expected 0", duty); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (level_on !== 1'b0) begin errors++; $display("FAIL reset_level_on: got %b expected 0", level_on); end
    checks++; if (dut.r_pwm_cnt !== 4'd0) begin errors++; $display("FAIL reset_pwm_cnt: got %0d expected 0", dut.r_pwm_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_ramp_up;
    logic [3:0] prev;
    logic [3:0] e;
    int hi;
    int eh;
    bit open;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL up_busy_start: got %b expected 1", busy); end
    checks++; if (level_on !== 1'b0) begin errors++; $display("FAIL up_level_start: got %b expected 0", level_on); end
    exp_q = '{4'd4, 4'd8, 4'd12, 4'd15};
    hi_q  = '{4, 8, 12};
    prev = duty; hi = 0; open = 1'b0;
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
      step();
      if (duty !== prev) begin
        if (open && hi_q.size() > 0) begin
          eh = hi_q.pop_front();
          checks++; if (hi !== eh) begin errors++; $display("FAIL up_high_cycles: got %0d expected %0d", hi, eh); end
        end
        e = exp_q.pop_front();
        checks++; if (duty !== e) begin errors++; $display("FAIL up_duty: got %0d expected %0d", duty, e); end
        prev = duty; open = 1'b1; hi = 0;
      end
      if (pwm_out === 1'b1) hi++;
    end
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL up_timeout: got %0d steps left expected 0", exp_q.size());
      exp_q.delete(); hi_q.delete();
    end
    checks++; if (level_on !== 1'b1) begin errors++; $display("FAIL up_level_on: got %b expected 1", level_on); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL up_busy_end: got %b expected 0", busy); end
    step();
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pwm_out !== 1'b1) hi++;
    end
    checks++; if (hi !== 0) begin errors++; $display("FAIL on_pwm_const: got %0d low cycles expected 0", hi); end
  endtask

  task automatic test_ramp_down;
    logic [3:0] prev;
    logic [3:0] e;
    int bad;
    blink_in = 1'b0;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL down_busy_start: got %b expected 1", busy); end
    checks++; if (level_on !== 1'b0) begin errors++; $display("FAIL down_level_start: got %b expected 0", level_on); end
    checks++; if (duty !== 4'd15) begin errors++; $display("FAIL down_duty_held: got %0d expected 15", duty); end
    exp_q = '{4'd11, 4'd7, 4'd3, 4'd0};
    prev = duty;
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
      step();
      if (duty !== prev) begin
        e = exp_q.pop_front();
        checks++; if (duty !== e) begin errors++; $display("FAIL down_duty: got %0d expected %0d", duty, e); end
        prev = duty;
      end
    end
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL down_timeout: got %0d steps left expected 0", exp_q.size());
      exp_q.delete();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL down_busy_end: got %b expected 0", busy); end
    checks++; if (level_on !== 1'b0) begin errors++; $display("FAIL down_level_end: got %b expected 0", level_on); end
    step();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (pwm_out !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL off_pwm_const: got %0d high cycles expected 0", bad); end
  endtask

  task automatic test_reversal;
    logic [3:0] prev;
    logic [3:0] e;
    bit ok;
    blink_in = 1'b1;
    wait_duty(4'd8, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rev_reach8: got duty %0d expected 8", duty); end
    blink_in = 1'b0;
    step();
    checks++; if (duty !== 4'd8) begin errors++; $display("FAIL rev_duty_held: got %0d expected 8", duty); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rev_busy: got %b expected 1", busy); end
    exp_q = '{4'd4, 4'd0};
    prev = duty;
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) begin
      step();
      if (duty !== prev) begin
        e = exp_q.pop_front();
        checks++; if (duty !== e) begin errors++; $display("FAIL rev_down_duty: got %0d expected %0d", duty, e); end
        prev = duty;
      end
    end
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL rev_timeout: got %0d steps left expected 0", exp_q.size());
      exp_q.delete();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rev_off_busy: got %b expected 0", busy); end

    // Raise the target in DOWN exactly on the period-end edge.
    blink_in = 1'b1;
    wait_duty(4'd8, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rev2_reach8: got duty %0d expected 8", duty); end
    blink_in = 1'b0;
    for (int i = 0; i < 20 && tb_cnt != 4'd15; i++) step();
    blink_in = 1'b1;
    step();
    checks++; if (duty !== 4'd8) begin errors++; $display("FAIL rev2_coincident_duty: got %0d expected 8", duty); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rev2_busy: got %b expected 1", busy); end
    exp_q.push_back(4'd12);
    prev = duty;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      step();
      if (duty !== prev) begin
        e = exp_q.pop_front();
        checks++; if (duty !== e) begin errors++; $display("FAIL rev2_up_duty: got %0d expected %0d", duty, e); end
        prev = duty;
      end
    end
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL rev2_timeout: got %0d steps left expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_pwm_shape;
    logic [3:0] nc;
    logic eb;
    bit ok;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0; blink_in = 1'b1; enable = 1'b1;
    wait_duty(4'd4, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL shape_reach4: got duty %0d expected 4", duty); end
    // Toggle the target on each period end so duty stays at 4 across periods.
    for (int i = 0; i < 48; i++) begin
      nc = tb_cnt + 4'd1;
      exp_bit_q.push_back((nc >= 4'd1) && (nc <= 4'd4));
      if (tb_cnt == 4'd15) blink_in = ~blink_in;
      step();
      eb = exp_bit_q.pop_front();
      checks++; if (pwm_out !== eb) begin errors++; $display("FAIL shape_pwm: got %b expected %b at cnt %0d", pwm_out, eb, tb_cnt); end
    end
    checks++; if (duty !== 4'd4) begin errors++; $display("FAIL shape_duty_held: got %0d expected 4", duty); end
  endtask

  task automatic test_enable_reset;
    logic [3:0] prev;
    logic [3:0] e;
    int bad;
    bit ok;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0; enable = 1'b0; blink_in = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (pwm_out !== 1'b0 || busy !== 1'b0 || level_on !== 1'b0 || duty !== 4'd0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL en_off_hold: got %0d active cycles expected 0", bad); end
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (level_on === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL en_reach_on: got level_on %b expected 1", level_on); end
    checks++; if (duty !== 4'd15) begin errors++; $display("FAIL en_on_duty: got %0d expected 15", duty); end
    enable = 1'b0;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL en_drop_busy: got %b expected 1", busy); end
    exp_q = '{4'd11, 4'd7, 4'd3, 4'd0};
    prev = duty;
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
      step();
      if (duty !== prev) begin
        e = exp_q.pop_front();
        checks++; if (duty !== e) begin errors++; $display("FAIL en_down_duty: got %0d expected %0d", duty, e); end
        prev = duty;
      end
    end
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL en_timeout: got %0d steps left expected 0", exp_q.size());
      exp_q.delete();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_off_busy: got %b expected 0", busy); end

    // Reset in the middle of a ramp at duty 8 while the LED is driven high.
    enable = 1'b1;
    wait_duty(4'd8, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_reach8: got duty %0d expected 8", duty); end
    repeat (3) step();
    checks++; if (pwm_out !== 1'b1) begin errors++; $display("FAIL rst_pre_pwm: got %b expected 1", pwm_out); end
    rst = 1'b1;
    step();
    checks++; if (duty !== 4'd0) begin errors++; $display("FAIL rst_mid_duty: got %0d expected 0", duty); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    checks++; if (level_on !== 1'b0) begin errors++; $display("FAIL rst_mid_level: got %b expected 0", level_on); end
    checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL rst_mid_pwm: got %b expected 0", pwm_out); end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_reversal();
    test_pwm_shape();
    test_enable_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
